// File: rtl/fifo_read_packer_if.sv
// Stream bundle for fifo_read_packer: upstream FIFO read port, flush request,
// packed valid/ready output stream and the busy indicator.
// The packer attaches through the master modport; the environment uses slave.
interface fifo_read_packer_if #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned PACK_NUM  = 4
);
    localparam int unsigned CNT_WIDTH = $clog2(PACK_NUM + 1);

    logic                          fifo_empty;
    logic                          fifo_read_en;
    logic [BIT_WIDTH-1:0]          fifo_read_data;
    logic                          flush;
    logic                          out_valid;
    logic                          out_ready;
    logic [BIT_WIDTH*PACK_NUM-1:0] out_data;
    logic [CNT_WIDTH-1:0]          out_lanes;
    logic                          busy;

    modport master (
        input  fifo_empty, fifo_read_data, flush, out_ready,
        output fifo_read_en, out_valid, out_data, out_lanes, busy
    );

    modport slave (
        output fifo_empty, fifo_read_data, flush, out_ready,
        input  fifo_read_en, out_valid, out_data, out_lanes, busy
    );
endinterface

// File: rtl/fifo_read_packer.sv
// fifo_read_packer: drains a combinational-read FIFO and packs PACK_NUM
// BIT_WIDTH words into one wide word on a valid/ready stream. An assembly
// register plus an output register keep the FIFO draining at full rate while
// the consumer holds a word. A flush emits the partial word, zero-padded.
// Optional build macro PACK_MSB_FIRST_EN: fill lanes from the top lane down
// (default fills from lane 0 upward).
module fifo_read_packer #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned PACK_NUM  = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_read_packer_if.master bus
);
    localparam int unsigned CNT_WIDTH  = $clog2(PACK_NUM + 1);
    localparam int unsigned LANE_WIDTH = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(PACK_NUM - 1);

    localparam logic [0:0] ST_ASSEMBLE   = 1'b0;
    localparam logic [0:0] ST_FLUSH_WAIT = 1'b1;

    typedef logic [PACK_NUM-1:0][BIT_WIDTH-1:0] lanes_t;

    logic [0:0]           state, state_nxt;
    lanes_t               asm_data, asm_nxt, asm_wr;
    logic [CNT_WIDTH-1:0] asm_cnt, cnt_nxt, cnt_wr;
    logic                 out_valid_q, ov_nxt;
    lanes_t               out_data_q, od_nxt;
    logic [CNT_WIDTH-1:0] out_lanes_q, ol_nxt;

    logic                  slot_free;
    logic                  flush_pend;
    logic                  read_en;
    logic [LANE_WIDTH-1:0] lane_idx;
    logic                  emit;
    lanes_t                emit_word;
    logic [CNT_WIDTH-1:0]  emit_lanes;

    assign slot_free  = ~out_valid_q | bus.out_ready;
    assign flush_pend = (state == ST_FLUSH_WAIT);
    assign read_en    = ~rst & ~bus.fifo_empty & ~flush_pend
                      & ((asm_cnt != CNT_LAST) | slot_free);

`ifdef PACK_MSB_FIRST_EN
    assign lane_idx = LANE_WIDTH'(CNT_LAST - asm_cnt);
`else
    assign lane_idx = LANE_WIDTH'(asm_cnt);
`endif

    assign bus.fifo_read_en = read_en;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_lanes    = out_lanes_q;
    assign bus.busy         = (asm_cnt != '0) | flush_pend;

    // Assembly contents and lane count as they would look after this cycle's read
    always_comb begin
        asm_wr = asm_data;
        if (read_en) begin
            asm_wr[lane_idx] = bus.fifo_read_data;
        end
        cnt_wr = asm_cnt + CNT_WIDTH'(read_en);
    end

    // Next state: word completion, flush handling and output slot update
    always_comb begin
        state_nxt  = state;
        asm_nxt    = asm_data;
        cnt_nxt    = asm_cnt;
        ov_nxt     = out_valid_q & ~bus.out_ready;
        od_nxt     = out_data_q;
        ol_nxt     = out_lanes_q;
        emit       = 1'b0;
        emit_word  = asm_wr;
        emit_lanes = cnt_wr;

        case (state)
            ST_ASSEMBLE: begin
                asm_nxt = asm_wr;
                cnt_nxt = cnt_wr;
                if (read_en && (asm_cnt == CNT_LAST)) begin
                    // a read on the last lane always has a free slot
                    emit = 1'b1;
                end else if (bus.flush && (cnt_wr != '0)) begin
                    if (slot_free) begin
                        emit = 1'b1;
                    end else begin
                        state_nxt = ST_FLUSH_WAIT;
                    end
                end
            end
            ST_FLUSH_WAIT: begin
                if (slot_free) begin
                    emit       = 1'b1;
                    emit_word  = asm_data;
                    emit_lanes = asm_cnt;
                    state_nxt  = ST_ASSEMBLE;
                end
            end
            default: state_nxt = ST_ASSEMBLE;
        endcase

        if (emit) begin
            ov_nxt  = 1'b1;
            od_nxt  = emit_word;
            ol_nxt  = emit_lanes;
            asm_nxt = '0;
            cnt_nxt = '0;
        end
    end

    // State, assembly and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ASSEMBLE;
            asm_data    <= '0;
            asm_cnt     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lanes_q <= '0;
        end else begin
            state       <= state_nxt;
            asm_data    <= asm_nxt;
            asm_cnt     <= cnt_nxt;
            out_valid_q <= ov_nxt;
            out_data_q  <= od_nxt;
            out_lanes_q <= ol_nxt;
        end
    end
endmodule

// File: doc/fifo_read_packer.md
Name: fifo_read_packer

Overview:
- Drains an upstream synchronous FIFO (combinational read: data valid in the same cycle as read_en while not empty) and packs PACK_NUM consecutive BIT_WIDTH words into one wide word.
- Emits packed words on a valid/ready stream toward the PE-array input bus.
- Double-buffered: an assembly register plus an output register, so a full-rate FIFO can be drained while the consumer holds the previous word.
- A flush request emits a partial word, zero-padded, at the end of a feature-map row.

Parameters:
- BIT_WIDTH, 8, width of one FIFO word / one lane.
- PACK_NUM, 4, lanes per packed word (>=2).
- CNT_WIDTH, clog2(PACK_NUM+1), derived (localparam), width of lane counters.

Ports:
- clk  input  1  system clock
- rst  input  1  system reset; synchronous, active-high
- fifo_empty  input  1  upstream FIFO empty indicator
- fifo_read_en  output  1  upstream FIFO read enable (combinational)
- fifo_read_data  input  BIT_WIDTH  upstream FIFO read data, valid in the same cycle as fifo_read_en
- flush  input  1  single-cycle request to emit the current partial word
- out_valid  output  1  packed word valid
- out_ready  input  1  consumer accepts packed word
- out_data  output  BIT_WIDTH*PACK_NUM  packed word; lane k occupies bits [k*BIT_WIDTH +: BIT_WIDTH]
- out_lanes  output  CNT_WIDTH  number of valid lanes in out_data (1..PACK_NUM)
- busy  output  1  high when the assembly register holds data or a flush is pending

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_lanes=0.
  - Assembly count asm_cnt=0, assembly data=0, flush_pend=0.
  - fifo_read_en is forced to 0 while rst is high.
  - Reset mid-operation discards the partial assembly and any held output word; nothing is emitted.
- Output slot:
  - slot_free = ~out_valid | out_ready.
  - out_data, out_lanes and out_valid are registered; no combinational path from fifo_read_data to out_data.
- Read issue:
  - fifo_read_en = ~rst & ~fifo_empty & ~flush_pend & (asm_cnt != PACK_NUM-1 | slot_free).
  - fifo_read_en combinationally depends on out_ready.
- On a read:
  - fifo_read_data is written to lane asm_cnt and asm_cnt increments.
  - When the written lane is PACK_NUM-1: the full word (including this cycle's data) moves to the output register at the same edge, with out_valid=1 and out_lanes=PACK_NUM.
  - The assembly register then clears to 0 with asm_cnt=0.
- Throughput and latency:
  - Latency is 1 cycle from the last lane read to out_valid.
  - With out_ready held high and the FIFO non-empty, one packed word is produced every PACK_NUM cycles with no bubbles.
- Backpressure: if asm_cnt=PACK_NUM-1 and ~slot_free, no read is issued; already-assembled lanes are held unchanged.
- Output hold: while out_valid & ~out_ready, out_data and out_lanes are stable.
- Flush state machine (states ASSEMBLE, FLUSH_WAIT):
  - ASSEMBLE, flush=1, total lanes T = asm_cnt + (read this cycle ? 1 : 0):
    - T=0: no-op; no empty word is ever emitted.
    - T>0 and slot_free: emit the word with unused lanes zero and out_lanes=T. The read lane this cycle is included.
    - T>0 and ~slot_free: latch flush_pend=1 and go to FLUSH_WAIT.
  - FLUSH_WAIT:
    - No reads are issued.
    - On the first cycle with slot_free, emit the partial word (out_lanes=asm_cnt), clear flush_pend and return to ASSEMBLE.
    - A flush asserted while in FLUSH_WAIT is ignored.
  - flush coinciding with completion of a full word: the full word is emitted normally (out_lanes=PACK_NUM) and the flush is a no-op.
- busy = (asm_cnt != 0) | flush_pend.

Optional Feature:
- Macro: PACK_MSB_FIRST_EN.
- Defined: the first word read goes to the top lane (lane PACK_NUM-1) and later words fill downward. A partial flush leaves the low lanes zero.
- Undefined (default): the first word read goes to lane 0 (LSBs). A partial flush leaves the high lanes zero.
- out_lanes semantics, handshake and timing are identical in both builds.

Test Plan:
- Reset, then push 8'h11,22,33,44 with out_ready=1 -> one cycle after the 4th read: out_valid=1, out_data=32'h44332211, out_lanes=4; fifo_read_en high on 4 consecutive cycles.
- 12 words streamed with out_ready=1 -> 3 packed words on cycles 4, 8, 12 after the first read; no read bubbles.
- out_ready=0 with 8 words available -> first word is held; reads stop after the 3 lanes of the second word (asm_cnt=3). Raise out_ready -> the 4th read occurs the same cycle and the second word appears next cycle.
- Read 8'hA1, 8'hB2, then flush=1 with out_ready=1 and FIFO empty -> out_data=32'h0000B2A1, out_lanes=2, busy=0. Flush with asm_cnt=0 -> out_valid stays 0.
- Flush while out_valid=1 and out_ready=0 with 3 lanes held -> FLUSH_WAIT, fifo_read_en=0 despite a non-empty FIFO. Set out_ready=1 -> the held word is consumed, the partial word is emitted with out_lanes=3, and reads resume.
- Assert rst mid-assembly (2 lanes held) and while out_valid=1 -> next cycle out_valid=0, out_data=0, busy=0. Subsequent packing starts at lane 0.
